dm_responder: RTL
=================

# dm_responder

Memory-side responder for the pipeline's load/store port. It accepts one byte, halfword or word request at a time over a valid/ready handshake and services it against an internal word-organised array after a configurable wait. It returns read data, sign- or zero-extended, and an error flag over a second valid/ready handshake. It sits behind the EX/MEM stage as the target of the core's data accesses and replaces the single-cycle data memory when multi-cycle memory behaviour is required.

## Interface
- DEPTH_WORDS, 1024 — array depth in 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 2 — extra wait cycles per request before the array access; 0..15.
- clk  in  1  — clock; all state updates on rising edge.
- reset  in  1  — asynchronous, active-low reset.
- req_valid  in  1  — request present.
- req_ready  out  1  — responder can accept a request.
- req_wr  in  1  — 1 = store, 0 = load.
- req_addr  in  32  — byte address.
- req_wdata  in  32  — store data; the active bytes are right-justified (byte in [7:0], half in [15:0]).
- req_bwidth  in  2  — access width: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_sext  in  1  — load result sign-extended (1) or zero-extended (0).
- rsp_valid  out  1  — response present.
- rsp_ready  in  1  — consumer accepts response.
- rsp_rdata  out  32  — load result; 0 for stores and errors.
- rsp_err  out  1  — request was misaligned or reserved width; no array write occurred.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counter runs.
  - ACCESS: single array cycle.
  - RESP: rsp_valid=1.
- IDLE→WAIT when req_valid & req_ready and WAIT_CYCLES>0; IDLE→ACCESS when WAIT_CYCLES=0. All request fields are latched on the accept edge.
- WAIT: the 4-bit counter is loaded with WAIT_CYCLES-1 on accept and decrements each cycle. WAIT→ACCESS when the counter reaches 0.
- ACCESS→RESP unconditionally. RESP→IDLE on rsp_valid & rsp_ready.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so the array wraps around.
- Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0]. A half at addr[1]=1 selects [31:16].
- Stores update only the enabled byte lanes during the ACCESS cycle. Loads read in ACCESS, then extract and extend per the latched req_sext.
- Error conditions: bwidth=11, half with addr[0]=1, word with addr[1:0]≠0. On error: no write, rsp_rdata=0, rsp_err=1.
- Only one outstanding request exists at a time. req_valid while not IDLE is ignored (stalled).

## Timing
- Reset values:
  - state IDLE
  - req_ready=1
  - rsp_valid=0
  - rsp_rdata=0
  - rsp_err=0
  - counter 0
  - The array is not reset.
- Latency: the accept edge is edge 0. rsp_valid rises after edge WAIT_CYCLES+1, i.e. visible in cycle WAIT_CYCLES+2.
- rsp_rdata and rsp_err are registered and held stable while rsp_valid=1 and rsp_ready=0.
- The response-handshake edge returns the FSM to IDLE, so req_ready=1 in the next cycle. A new request cannot be accepted on the handshake edge itself.
- Minimum period per transaction: WAIT_CYCLES+3 cycles.
- Reset asserted mid-transaction: return to IDLE immediately; the outstanding response is dropped.
  - Reset before the ACCESS edge: no write occurs.
  - Reset after the ACCESS edge: the write stands.
- A store followed by a load to the same word returns the new data, because the transactions are serialised.

## Configuration
- DM_RESPONDER_ALIGN_CHECK_EN defined: misaligned half/word accesses raise rsp_err, as described above.
- Undefined: misaligned accesses are force-aligned by clearing addr[0] for halves and addr[1:0] for words, and complete normally with rsp_err=0. bwidth=11 still raises rsp_err.

## Structure
- Package dm_responder_pkg: width codes BW_BYTE/BW_HALF/BW_WORD/BW_RSVD, the FSM state enum, and the WAIT counter width constant.
- Sub-module dm_responder_ram: single-port synchronous array with 4-bit byte-write enable and registered read. The FSM, lane extract and extend logic stay in the top.

## Test plan
- WAIT_CYCLES=2: word store 0xDEADBEEF @0x10, then word load @0x10. Required: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid visible in the 4th cycle after each accept.
- Byte store 0x80 @0x13 over 0x00000000, then byte loads @0x13. With sext=1: 0xFFFFFF80. With sext=0: 0x00000080. Word load @0x10: 0x80000000.
- Half load @0x11 with the macro defined: rsp_err=1, rsp_rdata=0. Half store @0x11 does not change the word. With the macro undefined, the half store acts on @0x10.
- Hold rsp_ready=0 for 5 cycles: rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. A second req_valid is not accepted until the cycle after the handshake.
- DEPTH_WORDS=16: store 0x12345678 @0x40, then load @0x00. Required: 0x12345678 (address wrap).
- Assert reset during WAIT of a store: outputs return to reset values asynchronously, and a subsequent load of the same address shows the old data.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the dm_responder memory-side responder.
package dm_responder_pkg;

  // Access width codes carried on req_bwidth.
  typedef enum logic [1:0] {
    BW_BYTE = 2'b00,
    BW_HALF = 2'b01,
    BW_WORD = 2'b10,
    BW_RSVD = 2'b11
  } bwidth_e;

  // Request life cycle: accept, optional wait, one array cycle, response.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Width of the wait counter; holds wait counts 0..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dm_responder_ram.sv
// Single-port word array with per-byte write enables and a registered read port.
module dm_responder_ram
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Enabled cycles write the selected byte lanes and capture the old word.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// dm_responder: serialised byte/half/word load-store responder with a
// configurable wait before each array access.
// Optional feature macro: DM_RESPONDER_ALIGN_CHECK_EN (misaligned half/word
// accesses raise rsp_err; otherwise they are force-aligned).
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_bwidth,
  input  logic        req_sext,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  bwidth_e          bw_q;
  logic             sext_q;

  logic             accept;
  logic             isErr;
  logic [1:0]       effOff;
  logic [3:0]       byteEn;
  logic [31:0]      laneData;
  logic             ramEn;
  logic [3:0]       ramWe;
  logic [31:0]      ramRdata;
  logic [31:0]      shifted;
  logic [31:0]      loadData;
  logic             unused_addr;

  assign accept = req_valid && (state_q == ST_IDLE);

  // State and wait-counter registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture every request field on the accept edge so the inputs may change afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bw_q    <= BW_BYTE;
      sext_q  <= 1'b0;
    end else if (accept) begin
      wr_q    <= req_wr;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      bw_q    <= bwidth_e'(req_bwidth);
      sext_q  <= req_sext;
    end
  end

  // Next-state logic: accept in IDLE, count down, one array cycle, hold response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Classify the latched request and pick the byte offset actually used.
`ifdef DM_RESPONDER_ALIGN_CHECK_EN
  always_comb begin
    effOff = addr_q[1:0];
    isErr  = (bw_q == BW_RSVD) ||
             ((bw_q == BW_HALF) && addr_q[0]) ||
             ((bw_q == BW_WORD) && (addr_q[1:0] != 2'b00));
  end
`else
  always_comb begin
    effOff = addr_q[1:0];
    isErr  = (bw_q == BW_RSVD);
    if (bw_q == BW_HALF) begin
      effOff = {addr_q[1], 1'b0};
    end else if (bw_q == BW_WORD) begin
      effOff = 2'b00;
    end
  end
`endif

  // Replicate store data across lanes and enable only the addressed bytes.
  always_comb begin
    byteEn   = 4'b0000;
    laneData = wdata_q;
    case (bw_q)
      BW_BYTE: begin
        byteEn   = 4'b0001 << effOff;
        laneData = {4{wdata_q[7:0]}};
      end
      BW_HALF: begin
        byteEn   = 4'b0011 << effOff;
        laneData = {2{wdata_q[15:0]}};
      end
      BW_WORD: byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  assign ramEn = (state_q == ST_ACCESS);
  assign ramWe = (ramEn && wr_q && !isErr) ? byteEn : 4'b0000;

  dm_responder_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .en_i    (ramEn),
    .we_i    (ramWe),
    .addr_i  (addr_q[IDX_W+1:2]),
    .wdata_i (laneData),
    .rdata_o (ramRdata)
  );

  assign shifted = ramRdata >> {effOff, 3'b000};

  // Extract the addressed lane from the captured word and extend it.
  always_comb begin
    loadData = '0;
    case (bw_q)
      BW_BYTE: loadData = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      BW_HALF: loadData = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      BW_WORD: loadData = shifted;
      default: loadData = '0;
    endcase
  end

  // Upper address bits beyond the array simply wrap.
  assign unused_addr = ^addr_q[31:IDX_W+2];

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = (state_q == ST_RESP) && isErr;
  assign rsp_rdata = ((state_q == ST_RESP) && !wr_q && !isErr) ? loadData : '0;

endmodule
